data_memory: RTL and testbench
==============================

# data_memory

Parametrised, handshaked data memory: successor to the single-port chip-select memory. It adds valid/ready request and response channels, byte-lane write enables, a configurable read/write latency, and address error detection. It sits between the MIPS load/store stage and backing storage, and services one transaction at a time.

## Interface
- WIDTH, 32, data word width in bits; multiple of 8, ≥ 8
- DEPTH, 1024, number of words
- ADDR_W, 32, byte-address width
- LATENCY, 2, cycles from request acceptance to response valid; ≥ 1
- clk_i  input  1  single clock, all logic on rising edge
- rst_n_i  input  1  synchronous, active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  block can accept a request
- req_we_i  input  1  1 = write, 0 = read
- req_addr_i  input  ADDR_W  byte address
- req_be_i  input  WIDTH/8  byte-lane write enables; bit k covers data bits [8k+7:8k]
- req_data_i  input  WIDTH  write data
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  consumer accepts response
- rsp_data_o  output  WIDTH  read data; 0 for writes and errors
- rsp_err_o  output  1  request was misaligned or out of range

## Operation
- Define BL = log2(WIDTH/8). Word index = req_addr_i >> BL.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, go to WAIT, or to RESP directly if LATENCY = 1. Load the wait counter with LATENCY-2.
  - WAIT: counter decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid_o = 1. It holds with rsp_data_o/rsp_err_o stable until rsp_ready_i = 1, then returns to IDLE.
- Error: a request is in error if the low BL address bits are nonzero or the word index is ≥ DEPTH.
  - An error request performs no memory access.
  - The response carries rsp_err_o = 1 and rsp_data_o = 0.
- Write commit:
  - Writes commit at the acceptance edge, for enabled lanes only; disabled lanes keep their old value.
  - req_be_i = 0 is a legal no-op write that still produces a response.
- Read capture:
  - Read data is captured at the acceptance edge into a response register.
  - A read always returns the full word; req_be_i is ignored.
- Writes produce a response: rsp_data_o = 0, rsp_err_o = 0.
- Memory contents are not reset and are undefined until written.
- Output rules:
  - rsp_data_o and rsp_err_o are 0 whenever rsp_valid_o = 0. No tristate outputs.
  - The request inputs are ignored outside the IDLE acceptance cycle.

## Timing
- Reset (rst_n_i = 0 at a rising edge), values visible from the next cycle:
  - FSM goes to IDLE.
  - req_ready_o = 1.
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_err_o = 0.
  - Wait counter = 0.
- Reset mid-transaction:
  - The response is dropped.
  - A write already accepted remains committed.
- Latency: a request accepted at edge N gives rsp_valid_o = 1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput:
  - The response handshake at edge M returns the FSM to IDLE, with req_ready_o = 1 in the cycle after M.
  - Back-to-back transactions therefore run at one per LATENCY+1 cycles with rsp_ready_i held high.
- Backpressure: rsp_ready_i low holds RESP indefinitely with req_ready_o = 0. No request is lost or reordered.
- req_ready_o is a registered function of state and does not depend combinationally on req_valid_i.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10, LATENCY=2 → write response rsp_err_o=0 and data 0; read response data 0xDEADBEEF, 2 cycles after acceptance.
- Write 0x11223344 to 0x20 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read 0x20 → 0x11BB33DD.
- Read 0x22 (misaligned) and 0x1000 (index 1024 = DEPTH) → rsp_err_o=1 and rsp_data_o=0 for both; memory word 0 unchanged.
- Hold rsp_ready_i=0 for 5 cycles during RESP → rsp_valid_o and data stable; req_ready_o=0; a new req_valid_i is not accepted until the handshake completes.
- Assert rst_n_i in WAIT after a write of 0x55 to 0x8 → no response appears; a later read of 0x8 returns 0x55.
- LATENCY=1 build with rsp_ready_i tied high and 4 back-to-back reads → accepts every 2 cycles; each response arrives 1 cycle after its acceptance.

Source files
------------

// File: rtl/data_memory.sv
// Handshaked single-transaction data memory with byte-lane writes, fixed
// request-to-response latency and misaligned/out-of-range error reporting.
module data_memory #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [WIDTH/8-1:0] req_be_i,
  input  logic [WIDTH-1:0]   req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_data_o,
  output logic               rsp_err_o
);
  localparam int unsigned NB       = WIDTH / 8;
  localparam int unsigned BL       = $clog2(NB);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam int unsigned CNT_W    = (CNT_INIT > 0) ? $clog2(CNT_INIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_cap_err;
  logic [WIDTH-1:0] r_cap_data;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_word_idx;
  logic [IDX_W-1:0]  w_mem_idx;
  logic              w_misaligned;
  logic              w_oob;
  logic              w_err;
  logic              w_accept;
  logic [WIDTH-1:0]  w_rd_data;
  logic [WIDTH-1:0]  w_wr_word;

  always_comb begin
    w_word_idx   = req_addr_i >> BL;
    w_mem_idx    = w_word_idx[IDX_W-1:0];
    w_misaligned = |(req_addr_i & ADDR_W'((64'd1 << BL) - 64'd1));
    w_oob        = (64'(w_word_idx) >= 64'(DEPTH));
    w_err        = w_misaligned | w_oob;
    w_accept     = rst_n_i & r_req_ready & req_valid_i;
    w_rd_data    = (w_err || req_we_i) ? '0 : r_mem[w_mem_idx];
    // Read-modify-merge so disabled lanes keep their stored bytes.
    w_wr_word    = r_mem[w_mem_idx];
    for (int unsigned k = 0; k < NB; k++) begin
      if (req_be_i[k]) w_wr_word[8*k +: 8] = req_data_i[8*k +: 8];
    end
  end

  // Storage is deliberately unreset; an accepted write survives a later reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && req_we_i && !w_err) begin
      r_mem[w_mem_idx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_cap_data  <= '0;
      r_cap_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_cnt       <= CNT_W'(CNT_INIT);
            if (LATENCY == 1) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rd_data;
              r_rsp_err   <= w_err;
            end else begin
              r_state    <= S_WAIT;
              r_cap_data <= w_rd_data;
              r_cap_err  <= w_err;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_cap_data;
            r_rsp_err   <= r_cap_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: LATENCY=2 instance (a_*) driven through directed and
// random transactions against a word/byte-valid model; LATENCY=1 instance (b_*).
module tb_data_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_data, a_rsp_data;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_data, b_rsp_data;
  logic [3:0]  b_req_be;

  data_memory #(.WIDTH(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(2)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_be_i(a_req_be), .req_data_i(a_req_data),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_data_o(a_rsp_data), .rsp_err_o(a_rsp_err)
  );

  data_memory #(.WIDTH(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_be_i(b_req_be), .req_data_i(b_req_data),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_data_o(b_rsp_data), .rsp_err_o(b_rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word array plus per-byte "has been written" flags.
  logic [31:0] m_mem [1024];
  logic [3:0]  m_bv  [1024];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  function automatic void model_step(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                     input logic [31:0] wd, output logic [31:0] ed,
                                     output logic ee, output logic [31:0] mask);
    int unsigned idx;
    idx  = addr / 4;
    ee   = (addr % 4 != 0) || (idx >= 1024);
    ed   = '0;
    mask = '1;
    if (!ee && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          m_mem[idx][8*b +: 8] = wd[8*b +: 8];
          m_bv[idx][b] = 1'b1;
        end
      end
    end else if (!ee) begin
      ed = m_mem[idx];
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{m_bv[idx][b]}};
    end
  endfunction

  // Drives one request on instance a; lat = edges from acceptance edge to rsp_valid.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic ok);
    int n;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_be = be; a_req_data = wd;
    n = 0;
    while (a_req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_we = 1'($urandom); a_req_addr = $urandom;
    a_req_be = 4'($urandom); a_req_data = $urandom;
    lat = 0;
    while (a_rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    ok = (n < 50) && (a_rsp_valid === 1'b1);
    rd = a_rsp_data;
    er = a_rsp_err;
    if (ok) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h30; a_req_be = 4'hF; a_req_data = $urandom;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h0 || a_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: ready %b valid %b data %h err %b, expected 1 0 00000000 0",
               a_req_ready, a_rsp_valid, a_rsp_data, a_rsp_err);
    end
    n_cmp++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_data !== 32'h0 || b_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: ready %b valid %b data %h err %b, expected 1 0 00000000 0",
               b_req_ready, b_rsp_valid, b_rsp_data, b_rsp_err);
    end
    a_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_t v[2];
    logic [31:0] rd, md, mm; logic er, me, ok; int lat;
    v = '{'{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0},
          '{1'b0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0}};
    foreach (v[i]) begin
      a_txn(v[i].we, v[i].addr, v[i].be, v[i].wd, rd, er, lat, ok);
      model_step(v[i].we, v[i].addr, v[i].be, v[i].wd, md, me, mm);
      n_cmp++;
      if (ok !== 1'b1 || lat != 1) begin
        n_bad++; $display("FAIL basic_latency[%0d]: ok %b lat %0d, expected ok 1 lat 1", i, ok, lat);
      end
      n_cmp++;
      if (er !== v[i].ee || rd !== v[i].ed) begin
        n_bad++; $display("FAIL basic_rsp[%0d]: err %b data %h, expected err %b data %h",
                          i, er, rd, v[i].ee, v[i].ed);
      end
    end
  endtask

  task automatic test_byte_lanes();
    vec_t v[4];
    logic [31:0] rd, md, mm; logic er, me, ok; int lat;
    v = '{'{1'b1, 32'h20, 4'hF,    32'h11223344, 32'h0, 1'b0},
          '{1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0},
          '{1'b1, 32'h20, 4'h0,    32'hFFFFFFFF, 32'h0, 1'b0},
          '{1'b0, 32'h20, 4'hA,    32'h0,        32'h11BB33DD, 1'b0}};
    foreach (v[i]) begin
      a_txn(v[i].we, v[i].addr, v[i].be, v[i].wd, rd, er, lat, ok);
      model_step(v[i].we, v[i].addr, v[i].be, v[i].wd, md, me, mm);
      n_cmp++;
      if (ok !== 1'b1 || lat != 1 || er !== v[i].ee || rd !== v[i].ed) begin
        n_bad++; $display("FAIL lanes[%0d]: ok %b lat %0d err %b data %h, expected 1 1 %b %h",
                          i, ok, lat, er, rd, v[i].ee, v[i].ed);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v[6];
    logic [31:0] rd, md, mm; logic er, me, ok; int lat;
    v = '{'{1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 32'h0, 1'b0},
          '{1'b0, 32'h22,   4'hF, 32'h0,        32'h0, 1'b1},
          '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h0, 1'b1},
          '{1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1'b1},
          '{1'b1, 32'h2,    4'hF, 32'h87654321, 32'h0, 1'b1},
          '{1'b0, 32'h0,    4'hF, 32'h0,        32'hCAFEF00D, 1'b0}};
    foreach (v[i]) begin
      a_txn(v[i].we, v[i].addr, v[i].be, v[i].wd, rd, er, lat, ok);
      model_step(v[i].we, v[i].addr, v[i].be, v[i].wd, md, me, mm);
      n_cmp++;
      if (ok !== 1'b1 || lat != 1 || er !== v[i].ee || rd !== v[i].ed) begin
        n_bad++; $display("FAIL errors[%0d]: ok %b lat %0d err %b data %h, expected 1 1 %b %h",
                          i, ok, lat, er, rd, v[i].ee, v[i].ed);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, rd, md, mm; logic e0, er, me, ok; int n, lat;
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'($urandom);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    model_step(1'b0, 32'h10, 4'hF, 32'h0, md, me, mm);
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    d0 = a_rsp_data; e0 = a_rsp_err;
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || d0 !== md || e0 !== 1'b0) begin
      n_bad++; $display("FAIL bp_first: valid %b data %h err %b, expected 1 %h 0", a_rsp_valid, d0, e0, md);
    end
    // A competing write is held on the request channel for the whole stall.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10; a_req_be = 4'hF; a_req_data = ~md;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== d0 || a_rsp_err !== e0 || a_req_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d]: valid %b data %h err %b ready %b, expected 1 %h %b 0",
                          k, a_rsp_valid, a_rsp_data, a_rsp_err, a_req_ready, d0, e0);
      end
    end
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_data !== 32'h0 || a_rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL bp_release: valid %b ready %b data %h err %b, expected 0 1 00000000 0",
                        a_rsp_valid, a_req_ready, a_rsp_data, a_rsp_err);
    end
    a_txn(1'b0, 32'h10, 4'hF, 32'h0, rd, er, lat, ok);
    model_step(1'b0, 32'h10, 4'hF, 32'h0, md, me, mm);
    n_cmp++;
    if (ok !== 1'b1 || rd !== md || er !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_stray_write: ok %b data %h err %b, expected 1 %h 0", ok, rd, er, md);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, md, mm; logic er, me, ok; int lat;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h8; a_req_be = 4'hF; a_req_data = 32'h55;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    model_step(1'b1, 32'h8, 4'hF, 32'h55, md, me, mm);
    n_cmp++;
    if (a_req_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_wait: ready %b valid %b, expected 0 0", a_req_ready, a_rsp_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
        n_bad++; $display("FAIL rmid_dropped[%0d]: valid %b ready %b, expected 0 1", k, a_rsp_valid, a_req_ready);
      end
      @(posedge clk); #1;
    end
    a_txn(1'b0, 32'h8, 4'hF, 32'h0, rd, er, lat, ok);
    n_cmp++;
    if (ok !== 1'b1 || rd !== 32'h55 || er !== 1'b0) begin
      n_bad++; $display("FAIL rmid_committed: ok %b data %h err %b, expected 1 00000055 0", ok, rd, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, md, mm; logic [3:0] be; logic we, er, me, ok; int lat, r;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 2) addr = 32'($urandom_range(1020, 1027) * 4);
      else             addr = 32'($urandom_range(0, 15) * 4);
      we = 1'($urandom); be = 4'($urandom); wd = $urandom;
      a_txn(we, addr, be, wd, rd, er, lat, ok);
      model_step(we, addr, be, wd, md, me, mm);
      n_cmp++;
      if (ok !== 1'b1 || lat != 1 || er !== me || (rd & mm) !== (md & mm)) begin
        n_bad++; $display("FAIL random[%0d] we %b addr %h be %h: ok %b lat %0d err %b data %h, expected 1 1 %b %h (mask %h)",
                          i, we, addr, be, ok, lat, er, rd, me, md, mm);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bd[4], ed; int acc[8]; int cyc, n;
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    cyc = 0;
    b_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_req_we = (i < 4); b_req_addr = 32'h40 + 32'(4 * (i % 4)); b_req_be = 4'hF; b_req_data = bd[i % 4];
      n = 0;
      while (b_req_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; cyc++; n++; end
      acc[i] = cyc;
      @(posedge clk); #1; cyc++;
      ed = (i < 4) ? 32'h0 : bd[i % 4];
      n_cmp++;
      if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_err !== 1'b0 || b_rsp_data !== ed) begin
        n_bad++; $display("FAIL b2b_rsp[%0d]: valid %b ready %b err %b data %h, expected 1 0 0 %h",
                          i, b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_data, ed);
      end
      if (i > 0) begin
        n_cmp++;
        if (acc[i] - acc[i-1] != 2) begin
          n_bad++; $display("FAIL b2b_spacing[%0d]: %0d cycles, expected 2", i, acc[i] - acc[i-1]);
        end
      end
    end
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_idle: valid %b ready %b, expected 0 1", b_rsp_valid, b_req_ready);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) m_bv[i] = 4'h0;
    rst_n = 1'b0; a_rsp_ready = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_be = '0; a_req_data = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
